// File: rtl/cus19_ldst_unit.sv
// Load/store unit with an integrated data memory for the cus19 core.
// One request at a time, Wait_States extra cycles per access, sign/zero-extended load result.
module cus19_ldst_unit #(
    parameter int Data_Width     = 8,
    parameter int Addr_Width     = 11,
    parameter int Mem_Depth      = 2048,
    parameter int Reg_Addr_Width = 4,
    parameter int Wait_States    = 0,
    parameter int Cnt_Width      = 16
) (
    input  logic                      cus19_clk_in,
    input  logic                      cus19_rst_in,
    input  logic                      req_valid_in,
    output logic                      req_ready_out,
    input  logic                      req_ld_in,
    input  logic                      req_st_in,
    input  logic                      req_signed_in,
    input  logic [Addr_Width-1:0]     req_addr_in,
    input  logic [Data_Width-1:0]     req_data_in,
    input  logic [Reg_Addr_Width-1:0] req_rd_in,
    output logic                      resp_valid_out,
    output logic                      resp_is_ld_out,
    output logic [Reg_Addr_Width-1:0] resp_rd_out,
    output logic [Data_Width-1:0]     resp_data_out,
    output logic [2*Data_Width-1:0]   ld_result_out,
    output logic                      fault_out,
    output logic [Cnt_Width-1:0]      ld_cnt_out,
    output logic [Cnt_Width-1:0]      st_cnt_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int IDX_W = (Mem_Depth > 1) ? $clog2(Mem_Depth) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(Wait_States);
    localparam logic [Addr_Width:0] DEPTH_LIM = (Addr_Width + 1)'(Mem_Depth);

    logic [Data_Width-1:0] data_mem [Mem_Depth];

    state_t                    state_q, state_d;
    logic [3:0]                wait_q, wait_d;
    logic                      ld_q, st_q, signed_q;
    logic [Addr_Width-1:0]     addr_q;
    logic [Data_Width-1:0]     data_q;
    logic [Reg_Addr_Width-1:0] rd_q;
    logic                      fault_q, is_ld_q;
    logic [Reg_Addr_Width-1:0] resp_rd_q;
    logic [Data_Width-1:0]     resp_data_q;
    logic [2*Data_Width-1:0]   ld_result_q;
    logic [Cnt_Width-1:0]      ld_cnt_q, st_cnt_q;

    logic                      accept_s, access_s, fault_s, ok_ld_s, ok_st_s;
    logic [IDX_W-1:0]          idx_s;
    logic [Data_Width-1:0]     rd_word_s;

    assign accept_s  = req_valid_in & (state_q == IDLE);
    assign access_s  = (state_q == BUSY) & (wait_q == 4'd0);
    assign fault_s   = ({1'b0, addr_q} >= DEPTH_LIM) | (ld_q == st_q);
    assign ok_ld_s   = access_s & ~fault_s & ld_q;
    assign ok_st_s   = access_s & ~fault_s & st_q;
    // Faulted addresses never reach the array, so the truncated index is exact when used.
    assign idx_s     = addr_q[IDX_W-1:0];
    assign rd_word_s = data_mem[idx_s];

    always_ff @(posedge cus19_clk_in) begin
        if (cus19_rst_in) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = BUSY;
                    wait_d  = WAIT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_out  = 1'b0;
        resp_valid_out = 1'b0;
        fault_out      = 1'b0;
        resp_is_ld_out = 1'b0;
        case (state_q)
            IDLE: req_ready_out = 1'b1;
            RESP: begin
                resp_valid_out = 1'b1;
                fault_out      = fault_q;
                resp_is_ld_out = is_ld_q;
            end
            default: req_ready_out = 1'b0;
        endcase
    end

    always_ff @(posedge cus19_clk_in) begin
        if (cus19_rst_in) begin
            ld_q        <= 1'b0;
            st_q        <= 1'b0;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            fault_q     <= 1'b0;
            is_ld_q     <= 1'b0;
            resp_rd_q   <= '0;
            resp_data_q <= '0;
            ld_result_q <= '0;
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
        end else begin
            if (accept_s) begin
                ld_q     <= req_ld_in;
                st_q     <= req_st_in;
                signed_q <= req_signed_in;
                addr_q   <= req_addr_in;
                data_q   <= req_data_in;
                rd_q     <= req_rd_in;
            end
            if (access_s) begin
                fault_q <= fault_s;
                is_ld_q <= ld_q & ~fault_s;
            end
            if (ok_ld_s) begin
                resp_rd_q   <= rd_q;
                resp_data_q <= rd_word_s;
                ld_result_q <= signed_q ? {{Data_Width{rd_word_s[Data_Width-1]}}, rd_word_s}
                                        : {{Data_Width{1'b0}}, rd_word_s};
                if (ld_cnt_q != {Cnt_Width{1'b1}}) begin
                    ld_cnt_q <= ld_cnt_q + {{(Cnt_Width-1){1'b0}}, 1'b1};
                end
            end
            if (ok_st_s && (st_cnt_q != {Cnt_Width{1'b1}})) begin
                st_cnt_q <= st_cnt_q + {{(Cnt_Width-1){1'b0}}, 1'b1};
            end
        end
    end

    // The array is not reset; a reset on the access edge suppresses the write.
    always_ff @(posedge cus19_clk_in) begin
        if (ok_st_s && !cus19_rst_in) begin
            data_mem[idx_s] <= data_q;
        end
    end

    assign resp_rd_out   = resp_rd_q;
    assign resp_data_out = resp_data_q;
    assign ld_result_out = ld_result_q;
    assign ld_cnt_out    = ld_cnt_q;
    assign st_cnt_out    = st_cnt_q;

endmodule

// File: tb/tb_cus19_ldst_unit.sv
// Directed scoreboard bench: u0 has no wait states and a 1024-word memory,
// u3 has three wait states and 2-bit counters so saturation is reachable.
module tb_cus19_ldst_unit;

    typedef struct packed {
        logic        is_ld;
        logic        fault;
        logic [3:0]  rd;
        logic [7:0]  data;
        logic [15:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v3;
    logic        req_ld, req_st, req_signed;
    logic [10:0] req_addr;
    logic [7:0]  req_data;
    logic [3:0]  req_rd;

    logic        r0_ready, r0_valid, r0_isld, r0_fault;
    logic [3:0]  r0_rd;
    logic [7:0]  r0_data;
    logic [15:0] r0_res, r0_ldc, r0_stc;

    logic        r3_ready, r3_valid, r3_isld, r3_fault;
    logic [3:0]  r3_rd;
    logic [7:0]  r3_data;
    logic [15:0] r3_res;
    logic [1:0]  r3_ldc, r3_stc;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q3[$];
    time  acc_t, t1;

    always #5 clk = ~clk;

    cus19_ldst_unit #(.Mem_Depth(1024), .Wait_States(0)) u0 (
        .cus19_clk_in(clk), .cus19_rst_in(rst), .req_valid_in(v0), .req_ready_out(r0_ready),
        .req_ld_in(req_ld), .req_st_in(req_st), .req_signed_in(req_signed),
        .req_addr_in(req_addr), .req_data_in(req_data), .req_rd_in(req_rd),
        .resp_valid_out(r0_valid), .resp_is_ld_out(r0_isld), .resp_rd_out(r0_rd),
        .resp_data_out(r0_data), .ld_result_out(r0_res), .fault_out(r0_fault),
        .ld_cnt_out(r0_ldc), .st_cnt_out(r0_stc));

    cus19_ldst_unit #(.Wait_States(3), .Cnt_Width(2)) u3 (
        .cus19_clk_in(clk), .cus19_rst_in(rst), .req_valid_in(v3), .req_ready_out(r3_ready),
        .req_ld_in(req_ld), .req_st_in(req_st), .req_signed_in(req_signed),
        .req_addr_in(req_addr), .req_data_in(req_data), .req_rd_in(req_rd),
        .resp_valid_out(r3_valid), .resp_is_ld_out(r3_isld), .resp_rd_out(r3_rd),
        .resp_data_out(r3_data), .ld_result_out(r3_res), .fault_out(r3_fault),
        .ld_cnt_out(r3_ldc), .st_cnt_out(r3_stc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic is_ld, input logic fault, input logic [3:0] rd,
                                input logic [7:0] data, input logic [15:0] res);
        exp_t e;
        e.is_ld = is_ld; e.fault = fault; e.rd = rd; e.data = data; e.res = res;
        return e;
    endfunction

    function automatic logic rdy(input int inst);
        return (inst == 0) ? r0_ready : r3_ready;
    endfunction

    function automatic logic vld(input int inst);
        return (inst == 0) ? r0_valid : r3_valid;
    endfunction

    // Scoreboard for u0; fault_out must never appear without resp_valid_out.
    always @(negedge clk) begin
        exp_t e;
        if (r0_fault && !r0_valid) chk("u0_fault_without_resp", 32'(r0_fault), 32'd0);
        if (r0_valid) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_resp", 32'(r0_valid), 32'd0);
            end else begin
                e = q0.pop_front();
                chk("u0_is_ld", 32'(r0_isld), 32'(e.is_ld));
                chk("u0_fault", 32'(r0_fault), 32'(e.fault));
                if (e.is_ld) begin
                    chk("u0_rd", 32'(r0_rd), 32'(e.rd));
                    chk("u0_data", 32'(r0_data), 32'(e.data));
                    chk("u0_ld_result", 32'(r0_res), 32'(e.res));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (r3_fault && !r3_valid) chk("u3_fault_without_resp", 32'(r3_fault), 32'd0);
        if (r3_valid) begin
            if (q3.size() == 0) begin
                chk("u3_unexpected_resp", 32'(r3_valid), 32'd0);
            end else begin
                e = q3.pop_front();
                chk("u3_is_ld", 32'(r3_isld), 32'(e.is_ld));
                chk("u3_fault", 32'(r3_fault), 32'(e.fault));
                if (e.is_ld) begin
                    chk("u3_rd", 32'(r3_rd), 32'(e.rd));
                    chk("u3_data", 32'(r3_data), 32'(e.data));
                    chk("u3_ld_result", 32'(r3_res), 32'(e.res));
                end
            end
        end
    end

    // Drive one request, push its expectation, and check ready/resp timing until ready returns.
    task automatic issue(input int inst, input logic ld, input logic st, input logic sgn,
                         input logic [10:0] addr, input logic [7:0] data, input logic [3:0] rd,
                         input exp_t e, input bit keep);
        int  w;
        bit  ok;
        w = (inst == 0) ? 0 : 3;
        req_ld = ld; req_st = st; req_signed = sgn;
        req_addr = addr; req_data = data; req_rd = rd;
        if (inst == 0) v0 = 1'b1; else v3 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rdy(inst)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        if (!ok) begin
            v0 = 1'b0; v3 = 1'b0;
            return;
        end
        @(posedge clk);
        acc_t = $time;
        #1;
        if (!keep) begin
            if (inst == 0) v0 = 1'b0; else v3 = 1'b0;
        end
        if (inst == 0) q0.push_back(e); else q3.push_back(e);
        for (int n = 1; n <= 2 + w; n++) begin
            @(negedge clk);
            chk("ready_low_while_busy", 32'(rdy(inst)), 32'd0);
            chk("resp_timing", 32'(vld(inst)), 32'(n == 2 + w));
        end
        @(negedge clk);
        chk("ready_after_resp", 32'(rdy(inst)), 32'd1);
        chk("resp_single_cycle", 32'(vld(inst)), 32'd0);
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b0; v3 = 1'b0;
        req_ld = 1'b0; req_st = 1'b0; req_signed = 1'b0;
        req_addr = 11'd0; req_data = 8'd0; req_rd = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'({r0_ready, r3_ready}), 32'd3);
        chk("rst_resp_valid", 32'({r0_valid, r3_valid, r0_fault, r3_fault, r0_isld, r3_isld}), 32'd0);
        chk("rst_u0_outs", {r0_data, r0_res, 4'd0, r0_rd}, 32'd0);
        chk("rst_cnts", {r0_ldc, r0_stc}, 32'd0);

        u0.data_mem[2] = 8'd5;
        u0.data_mem[7] = 8'hF0;
        u3.data_mem[2] = 8'h33;
        u3.data_mem[9] = 8'h55;

        // Test 1: unsigned load with zero wait states.
        issue(0, 1'b1, 1'b0, 1'b0, 11'd2, 8'd0, 4'd2, mk(1'b1, 1'b0, 4'd2, 8'd5, 16'h0005), 1'b0);
        chk("t1_ld_cnt", 32'(r0_ldc), 32'd1);

        // Test 2: store then load back.
        issue(0, 1'b0, 1'b1, 1'b0, 11'd4, 8'd10, 4'd4, mk(1'b0, 1'b0, 4'd0, 8'd0, 16'd0), 1'b0);
        chk("t2_mem4", 32'(u0.data_mem[4]), 32'd10);
        chk("t2_st_cnt", 32'(r0_stc), 32'd1);
        issue(0, 1'b1, 1'b0, 1'b0, 11'd4, 8'd0, 4'd4, mk(1'b1, 1'b0, 4'd4, 8'd10, 16'h000A), 1'b0);

        // Test 4: sign versus zero extension.
        issue(0, 1'b1, 1'b0, 1'b1, 11'd7, 8'd0, 4'd7, mk(1'b1, 1'b0, 4'd7, 8'hF0, 16'hFFF0), 1'b0);
        issue(0, 1'b1, 1'b0, 1'b0, 11'd7, 8'd0, 4'd8, mk(1'b1, 1'b0, 4'd8, 8'hF0, 16'h00F0), 1'b0);
        chk("t4_ld_cnt", 32'(r0_ldc), 32'd4);

        // Test 5: faults leave memory, counters and the load result untouched.
        issue(0, 1'b0, 1'b1, 1'b0, 11'd1500, 8'h77, 4'd1, mk(1'b0, 1'b1, 4'd0, 8'd0, 16'd0), 1'b0);
        issue(0, 1'b1, 1'b1, 1'b0, 11'd3, 8'h66, 4'd3, mk(1'b0, 1'b1, 4'd0, 8'd0, 16'd0), 1'b0);
        issue(0, 1'b0, 1'b0, 1'b0, 11'd3, 8'h66, 4'd3, mk(1'b0, 1'b1, 4'd0, 8'd0, 16'd0), 1'b0);
        issue(0, 1'b1, 1'b0, 1'b1, 11'd1024, 8'd0, 4'd5, mk(1'b0, 1'b1, 4'd0, 8'd0, 16'd0), 1'b0);
        chk("t5_st_cnt", 32'(r0_stc), 32'd1);
        chk("t5_ld_cnt", 32'(r0_ldc), 32'd4);
        chk("t5_ld_result_held", 32'(r0_res), 32'h00F0);
        chk("t5_resp_data_held", {r0_rd, r0_data}, 32'h8F0);
        issue(0, 1'b0, 1'b1, 1'b0, 11'd1023, 8'h3C, 4'd0, mk(1'b0, 1'b0, 4'd0, 8'd0, 16'd0), 1'b0);
        chk("t5_last_word", 32'(u0.data_mem[1023]), 32'h3C);
        chk("t5_st_cnt_edge", 32'(r0_stc), 32'd2);

        // Test 3: three wait states, second request held valid across the response.
        issue(3, 1'b1, 1'b0, 1'b0, 11'd2, 8'd0, 4'd3, mk(1'b1, 1'b0, 4'd3, 8'h33, 16'h0033), 1'b1);
        t1 = acc_t;
        issue(3, 1'b0, 1'b1, 1'b0, 11'd6, 8'h5A, 4'd0, mk(1'b0, 1'b0, 4'd0, 8'd0, 16'd0), 1'b0);
        chk("t3_held_accept_cycles", 32'(acc_t - t1), 32'd60);
        chk("t3_mem6", 32'(u3.data_mem[6]), 32'h5A);

        // Saturating counters on the 2-bit instance.
        for (int k = 0; k < 3; k++) begin
            issue(3, 1'b1, 1'b0, 1'b1, 11'd6, 8'd0, 4'(k), mk(1'b1, 1'b0, 4'(k), 8'h5A, 16'h005A), 1'b0);
        end
        chk("sat_ld_cnt", 32'(r3_ldc), 32'd3);
        chk("sat_st_cnt", 32'(r3_stc), 32'd1);

        // Test 6: reset in the second BUSY cycle of a store.
        req_ld = 1'b0; req_st = 1'b1; req_signed = 1'b0;
        req_addr = 11'd9; req_data = 8'hAA; req_rd = 4'd0;
        v3 = 1'b1;
        @(posedge clk);
        #1 v3 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("t6_no_resp", 32'({r3_valid, r3_fault}), 32'd0);
            chk("t6_ready", 32'(r3_ready), 32'd1);
        end
        chk("t6_mem9", 32'(u3.data_mem[9]), 32'h55);
        chk("t6_u3_outs", {r3_data, r3_res, r3_rd, r3_ldc, r3_stc}, 32'd0);
        chk("t6_u0_cnts", {r0_ldc, r0_stc}, 32'd0);
        chk("drain", 32'(q0.size() + q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
